// File: rtl/ccu_ax_scheduler.sv
// ccu_ax_scheduler: round-robin arbiter that shares the single CCU AX slot
// between NoPorts requesters. It tracks one in-flight read and one in-flight
// write per port by cache line. A request is blocked while it conflicts with
// a line held by another port, or while its own port already has an
// outstanding transaction of the same type.
// Optional feature: define CCU_SCHED_STALL_CNT_EN to add stall_cnt_o. This
// saturating counter counts IDLE cycles in which at least one request is
// valid but none is eligible.
module ccu_ax_scheduler #(
  parameter int unsigned NoPorts      = 4,
  parameter int unsigned AxiAddrWidth = 64,
  parameter int unsigned LineBytes    = 16,
  localparam int unsigned IdxW        = (NoPorts > 2) ? $clog2(NoPorts) : 1
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NoPorts-1:0]              req_valid_i,
  input  logic [NoPorts-1:0]              req_write_i,
  input  logic [NoPorts*AxiAddrWidth-1:0] req_addr_i,
  output logic [NoPorts-1:0]              req_ready_o,
  output logic                            gnt_valid_o,
  output logic [IdxW-1:0]                 gnt_port_o,
  output logic                            gnt_write_o,
  output logic [AxiAddrWidth-1:0]         gnt_addr_o,
  input  logic                            gnt_ready_i,
  input  logic                            done_valid_i,
  input  logic [IdxW-1:0]                 done_port_i,
  input  logic                            done_write_i,
  output logic [2*NoPorts-1:0]            busy_o
`ifdef CCU_SCHED_STALL_CNT_EN
  ,
  output logic [15:0]                     stall_cnt_o
`endif
);

  localparam int unsigned LineOffset = $clog2(LineBytes);
  localparam int unsigned LineW      = AxiAddrWidth - LineOffset;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [IdxW-1:0]    rr_q;
  logic [NoPorts-1:0] rd_vld_q, wr_vld_q;
  logic [LineW-1:0]   rd_line_q [NoPorts];
  logic [LineW-1:0]   wr_line_q [NoPorts];
  logic [LineW-1:0]   req_line  [NoPorts];
  logic [NoPorts-1:0] elig;
  logic               pick_vld;
  logic [IdxW-1:0]    pick_idx;
  logic               handshake;
  logic [LineW-1:0]   gnt_line;
  int                 scan_idx;

  assign handshake   = (state_q == ST_GRANT) && gnt_ready_i;
  assign gnt_valid_o = (state_q == ST_GRANT);
  assign gnt_line    = gnt_addr_o[AxiAddrWidth-1:LineOffset];

  // Start line of each port's request.
  always_comb begin
    for (int p = 0; p < NoPorts; p++) begin
      req_line[p] = req_addr_i[p*AxiAddrWidth + LineOffset +: LineW];
    end
  end

  // A port is eligible when its same-type slot is free and no other port holds a conflicting line.
  always_comb begin
    elig = '0;
    for (int p = 0; p < NoPorts; p++) begin
      elig[p] = req_valid_i[p];
      if (req_write_i[p]) begin
        if (wr_vld_q[p]) elig[p] = 1'b0;
        for (int q = 0; q < NoPorts; q++) begin
          if (q != p) begin
            if ((rd_vld_q[q] && (rd_line_q[q] == req_line[p])) ||
                (wr_vld_q[q] && (wr_line_q[q] == req_line[p]))) elig[p] = 1'b0;
          end
        end
      end else begin
        if (rd_vld_q[p]) elig[p] = 1'b0;
        for (int q = 0; q < NoPorts; q++) begin
          if ((q != p) && wr_vld_q[q] && (wr_line_q[q] == req_line[p])) elig[p] = 1'b0;
        end
      end
    end
  end

  // Round-robin pick starting at rr_q, plus next-state logic.
  always_comb begin
    state_d  = state_q;
    pick_vld = 1'b0;
    pick_idx = '0;
    scan_idx = 0;
    for (int k = 0; k < NoPorts; k++) begin
      scan_idx = int'(rr_q) + k;
      if (scan_idx >= int'(NoPorts)) scan_idx = scan_idx - int'(NoPorts);
      if (!pick_vld && elig[scan_idx]) begin
        pick_vld = 1'b1;
        pick_idx = IdxW'(scan_idx);
      end
    end
    case (state_q)
      ST_IDLE:  if (pick_vld) state_d = ST_GRANT;
      ST_GRANT: if (gnt_ready_i) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Pop pulse to the granted port; suppressed while reset is asserted.
  always_comb begin
    req_ready_o = '0;
    if (handshake && rst_ni) req_ready_o[gnt_port_o] = 1'b1;
  end

  // Table valid bits exported as busy: even = read, odd = write.
  always_comb begin
    for (int p = 0; p < NoPorts; p++) begin
      busy_o[2*p]   = rd_vld_q[p];
      busy_o[2*p+1] = wr_vld_q[p];
    end
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Grant payload registers, loaded when IDLE picks a port.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      gnt_port_o  <= '0;
      gnt_write_o <= 1'b0;
      gnt_addr_o  <= '0;
    end else if ((state_q == ST_IDLE) && pick_vld) begin
      gnt_port_o  <= pick_idx;
      gnt_write_o <= req_write_i[pick_idx];
      gnt_addr_o  <= req_addr_i[int'(pick_idx)*AxiAddrWidth +: AxiAddrWidth];
    end
  end

  // Round-robin pointer moves past the port that was just accepted.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) rr_q <= '0;
    else if (handshake) rr_q <= (gnt_port_o == IdxW'(NoPorts - 1)) ? '0 : gnt_port_o + 1'b1;
  end

  // Table valid bits: completion clears, accepted grant sets (never the same entry).
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_vld_q <= '0;
      wr_vld_q <= '0;
    end else begin
      if (done_valid_i) begin
        if (done_write_i) wr_vld_q[done_port_i] <= 1'b0;
        else              rd_vld_q[done_port_i] <= 1'b0;
      end
      if (handshake) begin
        if (gnt_write_o) wr_vld_q[gnt_port_o] <= 1'b1;
        else             rd_vld_q[gnt_port_o] <= 1'b1;
      end
    end
  end

  // Table line storage; contents only meaningful while the matching valid bit is set.
  always_ff @(posedge clk_i) begin
    if (handshake) begin
      if (gnt_write_o) wr_line_q[gnt_port_o] <= gnt_line;
      else             rd_line_q[gnt_port_o] <= gnt_line;
    end
  end

`ifdef CCU_SCHED_STALL_CNT_EN
  // Saturating count of IDLE cycles where requests are pending but all are blocked.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) stall_cnt_o <= '0;
    else if ((state_q == ST_IDLE) && (|req_valid_i) && !pick_vld && (stall_cnt_o != 16'hFFFF))
      stall_cnt_o <= stall_cnt_o + 16'd1;
  end
`endif

endmodule

// File: tb/tb_ccu_ax_scheduler.sv
// Self-checking bench for ccu_ax_scheduler (4 ports, 64-bit address, 16-byte lines).
// Build with CCU_SCHED_STALL_CNT_EN defined to also cover the stall counter.
module tb_ccu_ax_scheduler;

  localparam int NP = 4;
  localparam int AW = 64;
  localparam logic [63:0] LINE_BYTES = 64'd16;

  logic            clk;
  logic            rst_ni;
  logic [NP-1:0]   req_valid;
  logic [NP-1:0]   req_write;
  logic [63:0]     req_addr [NP];
  logic [NP*AW-1:0] req_addr_flat;
  logic [NP-1:0]   req_ready_o;
  logic            gnt_valid_o;
  logic [1:0]      gnt_port_o;
  logic            gnt_write_o;
  logic [AW-1:0]   gnt_addr_o;
  logic            gnt_ready;
  logic            done_valid;
  logic [1:0]      done_port;
  logic            done_write;
  logic [2*NP-1:0] busy_o;
`ifdef CCU_SCHED_STALL_CNT_EN
  logic [15:0]     stall_cnt_o;
`endif

  ccu_ax_scheduler #(.NoPorts(NP), .AxiAddrWidth(AW), .LineBytes(16)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid),
    .req_write_i  (req_write),
    .req_addr_i   (req_addr_flat),
    .req_ready_o  (req_ready_o),
    .gnt_valid_o  (gnt_valid_o),
    .gnt_port_o   (gnt_port_o),
    .gnt_write_o  (gnt_write_o),
    .gnt_addr_o   (gnt_addr_o),
    .gnt_ready_i  (gnt_ready),
    .done_valid_i (done_valid),
    .done_port_i  (done_port),
    .done_write_i (done_write),
    .busy_o       (busy_o)
`ifdef CCU_SCHED_STALL_CNT_EN
    ,
    .stall_cnt_o  (stall_cnt_o)
`endif
  );

  always_comb begin
    for (int p = 0; p < NP; p++) req_addr_flat[p*AW +: AW] = req_addr[p];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Outstanding transactions per port/type, pending grant and fairness pointer.
  bit          m_rv [NP];
  bit          m_wv [NP];
  logic [63:0] m_rl [NP];
  logic [63:0] m_wl [NP];
  bit          m_gv;
  int          m_port;
  bit          m_write;
  logic [63:0] m_addr;
  int          m_rr;
  int          m_stall;

  function automatic bit m_eligible(input int p);
    logic [63:0] ln;
    ln = req_addr[p] / LINE_BYTES;
    if (!req_valid[p]) return 1'b0;
    if (req_write[p]) begin
      if (m_wv[p]) return 1'b0;
      for (int q = 0; q < NP; q++)
        if (q != p && ((m_rv[q] && m_rl[q] == ln) || (m_wv[q] && m_wl[q] == ln))) return 1'b0;
    end else begin
      if (m_rv[p]) return 1'b0;
      for (int q = 0; q < NP; q++)
        if (q != p && m_wv[q] && m_wl[q] == ln) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    int pick;
    cyc++;
    if (!rst_ni) begin
      for (int p = 0; p < NP; p++) begin m_rv[p] = 0; m_wv[p] = 0; end
      m_gv = 0; m_port = 0; m_write = 0; m_addr = '0; m_rr = 0; m_stall = 0;
    end else begin
      bit rec; int rec_port; bit rec_write; logic [63:0] rec_line;
      rec = 0; rec_port = 0; rec_write = 0; rec_line = '0;
      if (m_gv) begin
        if (gnt_ready) begin
          rec = 1; rec_port = m_port; rec_write = m_write; rec_line = m_addr / LINE_BYTES;
          m_rr = (m_port + 1) % NP;
          m_gv = 0;
        end
      end else begin
        pick = -1;
        for (int k = 0; k < NP; k++)
          if (pick < 0 && m_eligible((m_rr + k) % NP)) pick = (m_rr + k) % NP;
        if (pick >= 0) begin
          m_gv = 1; m_port = pick; m_write = req_write[pick]; m_addr = req_addr[pick];
        end else if (|req_valid && m_stall < 65535) begin
          m_stall++;
        end
      end
      if (done_valid) begin
        if (done_write) m_wv[done_port] = 0;
        else            m_rv[done_port] = 0;
      end
      if (rec) begin
        if (rec_write) begin m_wv[rec_port] = 1; m_wl[rec_port] = rec_line; end
        else           begin m_rv[rec_port] = 1; m_rl[rec_port] = rec_line; end
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [NP-1:0]   exp_rdy;
      logic [2*NP-1:0] exp_busy;
      exp_rdy = '0;
      if (m_gv && gnt_ready && rst_ni) exp_rdy[m_port] = 1'b1;
      for (int p = 0; p < NP; p++) begin
        exp_busy[2*p]   = m_rv[p];
        exp_busy[2*p+1] = m_wv[p];
      end
      chk("model_gnt_valid", 64'(gnt_valid_o), 64'(m_gv));
      chk("model_req_ready", 64'(req_ready_o), 64'(exp_rdy));
      chk("model_busy", 64'(busy_o), 64'(exp_busy));
      if (m_gv) begin
        chk("model_gnt_port", 64'(gnt_port_o), 64'(m_port));
        chk("model_gnt_write", 64'(gnt_write_o), 64'(m_write));
        chk("model_gnt_addr", gnt_addr_o, m_addr);
      end
`ifdef CCU_SCHED_STALL_CNT_EN
      chk("model_stall_cnt", 64'(stall_cnt_o), 64'(m_stall));
`endif
    end
  end

  // Record pops (port and cycle) for the stimulus and for ordering checks.
  logic [NP-1:0] pop_vec;
  int log_port [$];
  int log_cyc  [$];
  always @(negedge clk) begin
    pop_vec = req_ready_o;
    for (int p = 0; p < NP; p++)
      if (req_ready_o[p] === 1'b1) begin log_port.push_back(p); log_cyc.push_back(cyc); end
  end

  // ---------------- stimulus helpers ----------------
  bit hold_valid = 0;
  bit auto_done  = 0;

  task automatic tick();
    @(posedge clk); #1;
    done_valid = 1'b0;
    for (int p = 0; p < NP; p++) begin
      if (pop_vec[p] === 1'b1) begin
        if (!hold_valid) req_valid[p] = 1'b0;
        if (auto_done) begin
          done_valid = 1'b1; done_port = 2'(p); done_write = req_write[p];
        end
      end
    end
  endtask

  task automatic set_req(input int p, input bit w, input logic [63:0] a);
    req_valid[p] = 1'b1; req_write[p] = w; req_addr[p] = a;
  endtask

  task automatic set_done(input int p, input bit w);
    done_valid = 1'b1; done_port = 2'(p); done_write = w;
  endtask

  task automatic wait_gnt(input string name, input int port, input int budget);
    bit ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      @(negedge clk);
      if (gnt_valid_o === 1'b1 && gnt_port_o === 2'(port)) ok = 1;
    end
    n_assert++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: port %0d not granted within %0d cycles, gnt_valid=%b gnt_port=%0d",
               name, port, budget, gnt_valid_o, gnt_port_o);
    end
  endtask

  task automatic do_reset();
    rst_ni = 1'b0; req_valid = '0; done_valid = 1'b0;
    tick(); tick();
    rst_ni = 1'b1;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0; req_valid = '0; req_write = '0; gnt_ready = 1'b1;
    done_valid = 1'b0; done_port = '0; done_write = 1'b0; pop_vec = '0;
    for (int p = 0; p < NP; p++) req_addr[p] = '0;
    tick(); tick();
    chk_en = 1;
    @(negedge clk);
    chk("rst_gnt_valid", 64'(gnt_valid_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_gnt_addr", gnt_addr_o, 64'd0);
    chk("rst_gnt_port", 64'(gnt_port_o), 64'd0);
    rst_ni = 1'b1;
    tick();

    // Single request, no conflict.
    set_req(1, 1'b1, 64'h1000);
    @(negedge clk);
    chk("single_c0_gnt_valid", 64'(gnt_valid_o), 64'd0);
    tick();
    @(negedge clk);
    chk("single_c1_gnt_valid", 64'(gnt_valid_o), 64'd1);
    chk("single_c1_gnt_port", 64'(gnt_port_o), 64'd1);
    chk("single_c1_gnt_addr", gnt_addr_o, 64'h1000);
    chk("single_c1_gnt_write", 64'(gnt_write_o), 64'd1);
    chk("single_c1_req_ready", 64'(req_ready_o), 64'h2);
    tick();
    @(negedge clk);
    chk("single_c2_busy3", 64'(busy_o[3]), 64'd1);
    chk("single_c2_gnt_valid", 64'(gnt_valid_o), 64'd0);
    tick();
    set_done(1, 1'b1);
    tick();
    @(negedge clk);
    chk("single_done_busy", 64'(busy_o), 64'd0);

    // Round-robin fairness with continuous reads on distinct lines.
    tick();
    do_reset();
    log_port.delete(); log_cyc.delete();
    hold_valid = 1; auto_done = 1;
    set_req(0, 1'b0, 64'h100); set_req(1, 1'b0, 64'h200);
    set_req(2, 1'b0, 64'h300); set_req(3, 1'b0, 64'h400);
    repeat (10) tick();
    req_valid = '0; hold_valid = 0;
    tick();
    auto_done = 0;
    tick(); tick();
    n_assert++;
    if (log_port.size() < 5) begin
      n_fail++;
      $display("FAIL rr_count: got %0d grants, expected at least 5", log_port.size());
    end else begin
      int exp_order [5] = '{0, 1, 2, 3, 0};
      for (int i = 0; i < 5; i++) chk($sformatf("rr_order_%0d", i), 64'(log_port[i]), 64'(exp_order[i]));
      for (int i = 1; i < 5; i++) chk($sformatf("rr_spacing_%0d", i), 64'(log_cyc[i] - log_cyc[i-1]), 64'd2);
    end

    // Line conflict: write held by port 0 blocks a read to the same line.
    set_req(0, 1'b1, 64'h2000);
    wait_gnt("conflict_setup", 0, 4);
    tick();
    set_req(2, 1'b0, 64'h2008);
    repeat (8) begin
      @(negedge clk);
      chk("conflict_blocked", 64'(gnt_valid_o), 64'd0);
      chk("conflict_busy1", 64'(busy_o[1]), 64'd1);
      tick();
    end
    set_done(0, 1'b1);
    wait_gnt("conflict_release", 2, 2);
    tick();
    set_done(2, 1'b0);
    tick();

    // Read-read sharing, then same-port reissue blocked until completion.
    set_req(0, 1'b0, 64'h3000); set_req(1, 1'b0, 64'h3000);
    repeat (6) tick();
    @(negedge clk);
    chk("share_busy", 64'(busy_o), 64'h05);
    tick();
    set_req(0, 1'b0, 64'h3040);
    repeat (5) begin
      @(negedge clk);
      chk("same_port_blocked", 64'(gnt_valid_o), 64'd0);
      tick();
    end
    set_done(0, 1'b0);
    wait_gnt("same_port_release", 0, 2);
    tick();
    set_done(0, 1'b0);
    tick();

    // Backpressure holds the grant; reset mid-GRANT drops it without a pop.
    gnt_ready = 1'b0;
    set_req(3, 1'b1, 64'h4000);
    wait_gnt("bp_grant", 3, 3);
    repeat (5) begin
      tick();
      @(negedge clk);
      chk("bp_gnt_valid", 64'(gnt_valid_o), 64'd1);
      chk("bp_gnt_port", 64'(gnt_port_o), 64'd3);
      chk("bp_gnt_addr", gnt_addr_o, 64'h4000);
      chk("bp_req_ready", 64'(req_ready_o), 64'd0);
    end
    chk("bp_busy_before_rst", 64'(busy_o), 64'h04);
    tick();
    rst_ni = 1'b0; gnt_ready = 1'b1; req_valid = '0;
    @(negedge clk);
    chk("rst_no_pop", 64'(req_ready_o), 64'd0);
    tick();
    @(negedge clk);
    chk("rst_mid_gnt_valid", 64'(gnt_valid_o), 64'd0);
    chk("rst_mid_busy", 64'(busy_o), 64'd0);
    tick();
    rst_ni = 1'b1;
    tick();

`ifdef CCU_SCHED_STALL_CNT_EN
    // Stall counter: port 3 write blocked by port 0's read of the same line.
    @(negedge clk);
    chk("stall_start", 64'(stall_cnt_o), 64'd0);
    tick();
    set_req(0, 1'b0, 64'h5000);
    wait_gnt("stall_setup", 0, 4);
    tick();
    set_req(3, 1'b1, 64'h5000);
    repeat (10) tick();
    @(negedge clk);
    chk("stall_10", 64'(stall_cnt_o), 64'd10);
    repeat (69990) tick();
    @(negedge clk);
    chk("stall_sat", 64'(stall_cnt_o), 64'hFFFF);
`endif

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ccu_ax_scheduler.md
Name: ccu_ax_scheduler

Overview:
- Round-robin scheduler that shares the single CCU AX request slot between NoPorts cache-side requesters.
- Grants one AW or AR at a time. Tracks one in-flight read and one in-flight write per port in a cache-line table.
- Blocks requests that hit a line held by another port, and blocks same-type reissue from a port until its completion.
- Sits between the per-core request ports and the CCU dispatch/snoop logic.

Parameters:
- NoPorts, 4, number of requesting ports (2..8).
- AxiAddrWidth, 64, address width.
- LineBytes, 16, cache-line size in bytes (power of 2). LineOffset = log2(LineBytes).
- Local IdxW = max(1, $clog2(NoPorts)).

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_ni  in  1  reset, synchronous, active-low.
- req_valid_i  in  NoPorts  per-port request valid. Port must hold the request stable until its req_ready_o.
- req_write_i  in  NoPorts  1 = AW, 0 = AR.
- req_addr_i  in  NoPorts x AxiAddrWidth  request start address.
- req_ready_o  out  NoPorts  one-cycle pop pulse to the granted port.
- gnt_valid_o  out  1  granted request presented to the CCU.
- gnt_port_o  out  IdxW  granted port index.
- gnt_write_o  out  1  granted type.
- gnt_addr_o  out  AxiAddrWidth  granted address, unmodified.
- gnt_ready_i  in  1  CCU accepts the grant.
- done_valid_i  in  1  completion pulse (B handshake or R last).
- done_port_i  in  IdxW  completing port.
- done_write_i  in  1  completing type.
- busy_o  out  2*NoPorts  table valid bits: [2p] = read of port p, [2p+1] = write of port p.

Behaviour:
- Reset (rst_ni=0 at the edge):
  - FSM to IDLE; all table entries invalid; rr pointer = 0.
  - gnt_valid_o=0; gnt_port_o, gnt_write_o, gnt_addr_o = 0; req_ready_o=0; busy_o=0.
  - Reset asserted mid-GRANT drops gnt_valid_o at that edge. No table entry is recorded.
- Line address: line(a) = a >> LineOffset. Only the start line is compared; bursts crossing lines are not supported.
- Eligibility of port p (combinational, against the registered table only). All of:
  - req_valid_i[p]=1.
  - Port p's own entry of the same type is invalid.
  - Write request: no other port has a valid read or write entry with the same line.
  - Read request: no other port has a valid write entry with the same line.
  - Read-read overlap is allowed.
- FSM IDLE:
  - If any port is eligible, choose the first eligible index scanning rr, rr+1, …, wrapping modulo NoPorts.
  - Latch its port, type and address into output registers. Next state GRANT; gnt_valid_o=1 from the next cycle.
  - If no port is eligible, stay in IDLE.
- FSM GRANT:
  - Outputs held stable while gnt_ready_i=0.
  - On gnt_ready_i=1 in the same cycle:
    - req_ready_o[gnt_port_o]=1 combinationally.
    - The table entry (port, type) is written valid with line(gnt_addr_o) at the edge.
    - rr = (gnt_port_o+1) mod NoPorts; next state IDLE.
  - Minimum spacing between grants is 2 cycles.
- Completion: done_valid_i clears entry (done_port_i, done_write_i) at the edge.
  - Done on an already-invalid entry is ignored.
  - Done and a record on different entries in the same cycle: both take effect.
  - A same-entry collision cannot occur, because the entry must be invalid to be granted.
- Latency: request valid at cycle 0 with no conflict gives gnt_valid_o=1 at cycle 1.
- A port that becomes eligible is granted within NoPorts grants (starvation-free), provided its blocker completes.

Optional Feature:
- Macro: CCU_SCHED_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt_o [15:0], reset to 0.
  - Increments, saturating at 16'hFFFF, on every IDLE cycle where |req_valid_i=1 and no port is eligible.
  - Cleared only by reset.
- When undefined: port and counter are absent; the remaining behaviour is identical.

Test Plan:
- Single request, no conflict:
  - Port 1 issues a write at 0x1000 at cycle 0 → gnt_valid_o=1, gnt_port_o=1, gnt_addr_o=0x1000 at cycle 1.
  - gnt_ready_i=1 at cycle 1 → req_ready_o[1] pulse at cycle 1; busy_o[3]=1 from cycle 2.
- Round-robin fairness: ports 0–3 issue reads at distinct lines continuously, gnt_ready_i always 1 → grant order 0, 1, 2, 3, 0, one grant every 2 cycles.
- Line conflict:
  - Port 0 write at 0x2000 in flight; port 2 read at 0x2008 → never granted while the entry is valid.
  - done_valid_i (port 0, write) → port 2 granted within 2 cycles.
- Read-read sharing and same-port limit:
  - Ports 0 and 1 read at 0x3000 → both granted.
  - Port 0 issues a second read before its done → blocked until done.
- Backpressure and reset:
  - Hold gnt_ready_i=0 for 5 cycles → gnt_* outputs stable throughout.
  - Assert rst_ni=0 → gnt_valid_o=0 and busy_o=0 after the edge; no req_ready_o pulse occurs.
- Stall counter (macro on):
  - Only port 3 valid, blocked for 10 cycles → stall_cnt_o=10.
  - Force 70000 blocked cycles → stall_cnt_o=16'hFFFF.
